// File: rtl/lsu_if.sv
// lsu_if: data-RAM request/acknowledge bus between the load/store unit and memory
interface lsu_if #(
    parameter int n = 32
);
    logic         mem_req;
    logic         mem_we;
    logic [n-1:0] mem_addr;
    logic [3:0]   mem_be;
    logic [n-1:0] mem_wdata;
    logic         mem_ack;
    logic [n-1:0] mem_rdata;

    modport master(
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave(
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu.sv
// lsu: sequences one bus transaction per load/store, steers byte lanes, extends load data and flags faults
module lsu #(
    parameter int n   = 32,
    parameter int TMO = 15
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ld,
    input  logic         st,
    input  logic [2:0]   funct3,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] wdata,
    output logic [n-1:0] rdata,
    output logic         done,
    output logic         stall,
    output logic         fault,
    lsu_if.master        bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state, state_nx;
    logic [7:0]   timer;
    logic [1:0]   off;
    logic [2:0]   f3;
    logic         legal, aligned, go, ack_ok, tmo;
    logic [3:0]   be;
    logic [15:0]  s;
    logic [n-1:0] wd, ext;

    always_comb begin
        legal    = ld ? funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}
                      : funct3 inside {3'b000, 3'b001, 3'b010};
        aligned  = funct3[1:0] == 2'b01 ? ~addr[0] : funct3[1:0] == 2'b10 ? addr[1:0] == 2'b00 : 1'b1;
        go       = (ld ^ st) & legal & aligned;
        be       = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0]
                 : funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd       = ~st ? '0 : funct3[1:0] == 2'b00 ? {4{wdata[7:0]}}
                 : funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        ack_ok   = state == BUSY && bus.mem_ack;
        // an ack arriving in the final wait cycle wins over the timeout
        tmo      = state == BUSY && !bus.mem_ack && timer == 8'(TMO - 1);
        s        = 16'(bus.mem_rdata >> {off, 3'b000});
        ext      = f3 == 3'b000 ? {{24{s[7]}}, s[7:0]}
                 : f3 == 3'b001 ? {{16{s[15]}}, s[15:0]}
                 : f3 == 3'b100 ? {24'b0, s[7:0]}
                 : f3 == 3'b101 ? {16'b0, s[15:0]} : bus.mem_rdata;
        state_nx = state == IDLE ? ((ld | st) ? (go ? BUSY : DONE) : IDLE)
                 : state == BUSY ? ((ack_ok | tmo) ? DONE : BUSY) : IDLE;
    end

    assign done  = state == DONE;
    assign stall = (ld | st) & ~done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            timer         <= '0;
            off           <= '0;
            f3            <= '0;
            rdata         <= '0;
            fault         <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state <= state_nx;
            timer <= state == BUSY ? timer + 8'd1 : 8'd0;
            fault <= state_nx == DONE && !ack_ok;
            rdata <= (state == IDLE && state_nx == DONE) || tmo ? '0
                   : ack_ok && !bus.mem_we ? ext : rdata;
            if (state == IDLE && state_nx == BUSY) begin
                off           <= addr[1:0];
                f3            <= funct3;
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= st;
                bus.mem_addr  <= {addr[n-1:2], 2'b00};
                bus.mem_be    <= be;
                bus.mem_wdata <= wd;
            end else if (state_nx != BUSY) begin
                bus.mem_req   <= 1'b0;
                bus.mem_we    <= 1'b0;
                bus.mem_addr  <= '0;
                bus.mem_be    <= '0;
                bus.mem_wdata <= '0;
            end
        end
    end
endmodule
